// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and FSM state encoding for the UART receiver.
// Imported by the receiver top and its output buffer.
package uart_rx_fifo_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A write into a full FIFO is accepted only when a read frees a slot.
module sync_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             r_ovf;

  logic w_pop;
  logic w_wr;

  assign w_pop = i_pop && (r_count != '0);
  assign w_wr  = i_push && ((r_count != FULL) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf <= i_push && !w_wr;
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero when empty so reset shows m_data = 0
  assign o_valid    = (r_count != '0);
  assign o_data     = o_valid ? r_mem[r_rd] : '0;
  assign o_overflow = r_ovf;
  assign o_count    = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, mid-bit sampling FSM and shifter,
// feeding received words into a FWFT output buffer.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          uart_txd_in,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_BIT    = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP   = 1'(STOP_BITS - 1);
  localparam logic          ODD_SENSE   = (PARITY == PAR_ODD);

  rx_state_e            r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_par_err;
  logic                 r_stop_idx;
  logic                 r_frame_err;
  logic                 r_parity_err;

  logic w_tick;
  logic w_fall;
  logic w_push;

  assign w_tick = (r_cnt == '0);
  assign w_fall = r_prev && !r_sync2;
  assign w_push = (r_state == STOP) && w_tick && r_sync2
               && (r_stop_idx == LAST_STOP) && !r_par_err;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_prev       <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_par_err    <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_sync1      <= uart_txd_in;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      if (r_state != IDLE && r_state != WAIT_HIGH)
        r_cnt <= w_tick ? BIT_RELOAD : r_cnt - 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_cnt   <= HALF_RELOAD;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_sync2) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_bit     <= '0;
              r_par     <= 1'b0;
              r_par_err <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            r_par   <= r_par ^ r_sync2;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == LAST_BIT) begin
              r_state    <= (PARITY != PAR_NONE) ? PAR : STOP;
              r_stop_idx <= 1'b0;
            end
          end
        end
        PAR: begin
          if (w_tick) begin
            r_par_err <= r_sync2 != (r_par ^ ODD_SENSE);
            r_state   <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (!r_sync2) begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end else if (r_stop_idx == LAST_STOP) begin
              r_parity_err <= r_par_err;
              r_state      <= IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
        end
        WAIT_HIGH: begin
          if (r_sync2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (sysclk),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_data     (r_shift),
    .i_pop      (m_ready),
    .o_data     (m_data),
    .o_valid    (m_valid),
    .o_overflow (overrun),
    .o_count    (fifo_count)
  );

  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: two receivers (no parity/1 stop, even parity/2 stop)
// driven by directed and random frames, checked against a frame model.
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       line0, line1, rdy0, rdy1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;
  logic [4:0] cnt0, cnt1;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u0 (
    .sysclk(clk), .reset(rst), .uart_txd_in(line0),
    .m_data(data0), .m_valid(valid0), .m_ready(rdy0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
    .fifo_count(cnt0), .rx_busy(busy0)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u1 (
    .sysclk(clk), .reset(rst), .uart_txd_in(line1),
    .m_data(data1), .m_valid(valid1), .m_ready(rdy1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
    .fifo_count(cnt1), .rx_busy(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int exp_fe[2], exp_pe[2], exp_ov[2];
  int seen_fe[2], seen_pe[2], seen_ov[2];

  bit want0 = 1'b0, want1 = 1'b0, rnd_rdy = 1'b0;
  bit busy0_seen = 1'b0;
  logic pv0 = 1'b0;
  int rise0 = 0;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void check_rng(input string name, input int v,
                                    input int lo, input int hi);
    n_checks++;
    if (v >= lo && v <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
  endfunction

  // Reference: what a frame should produce, from the framing rules
  function automatic void model(input int d, input logic [7:0] w,
                                input logic pb, input logic [1:0] st);
    logic stop_ok;
    int   held;
    stop_ok = (d == 0) ? st[0] : (st[0] & st[1]);
    held    = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (!stop_ok) exp_fe[d]++;
    else if (d == 1 && pb != logic'($countones(w) % 2)) exp_pe[d]++;
    else if (held == 16) exp_ov[d]++;
    else if (d == 0) exp_q0.push_back(w);
    else exp_q1.push_back(w);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rdy0 = rnd_rdy ? 1'($urandom_range(0, 1)) : want0;
    rdy1 = rnd_rdy ? 1'($urandom_range(0, 1)) : want1;
  end

  // Monitor: pops the scoreboard on every accepted word
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (valid0 && rdy0) begin
        check("dut0 word expected", 32'(exp_q0.size() != 0), 1);
        if (exp_q0.size() != 0) check("dut0 data", data0, exp_q0.pop_front());
      end
      if (valid1 && rdy1) begin
        check("dut1 word expected", 32'(exp_q1.size() != 0), 1);
        if (exp_q1.size() != 0) check("dut1 data", data1, exp_q1.pop_front());
      end
      if (fe0) seen_fe[0]++;
      if (pe0) seen_pe[0]++;
      if (ov0) seen_ov[0]++;
      if (fe1) seen_fe[1]++;
      if (pe1) seen_pe[1]++;
      if (ov1) seen_ov[1]++;
      if (busy0) busy0_seen = 1'b1;
      if (valid0 && !pv0) rise0 = cyc;
      pv0 = valid0;
    end
  end

  task automatic set_line(input int d, input logic v);
    if (d == 0) line0 = v;
    else line1 = v;
  endtask

  task automatic bit_time(input int d, input logic v);
    set_line(d, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // pbit < 0 sends correct even parity; raise=0 leaves the line as last bit
  task automatic send_frame(input int d, input logic [7:0] w, input int pbit,
                            input logic [1:0] st, input bit raise,
                            output int t0);
    logic pb;
    pb = (pbit < 0) ? ^w : pbit[0];
    model(d, w, pb, st);
    @(posedge clk);
    #1;
    t0 = cyc;
    bit_time(d, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(d, w[i]);
    if (d == 1) bit_time(d, pb);
    bit_time(d, st[0]);
    if (d == 1) bit_time(d, st[1]);
    if (raise) set_line(d, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " valid0"}, valid0, 0);
    check({tag, " data0"}, data0, 0);
    check({tag, " count0"}, cnt0, 0);
    check({tag, " busy0"}, busy0, 0);
    check({tag, " pulses0"}, {fe0, pe0, ov0}, 0);
    check({tag, " valid1"}, valid1, 0);
    check({tag, " count1"}, cnt1, 0);
    check({tag, " busy1"}, busy1, 0);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((cnt0 != 0 || cnt1 != 0) && i < 400) begin
      @(posedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    check({name, " drained"}, 32'(cnt0 == 0 && cnt1 == 0), 1);
    check({name, " sb0 empty"}, exp_q0.size(), 0);
    check({name, " sb1 empty"}, exp_q1.size(), 0);
  endtask

  task automatic chk_errs(input string name);
    for (int d = 0; d < 2; d++) begin
      check({name, " frame_err count"}, seen_fe[d], exp_fe[d]);
      check({name, " parity_err count"}, seen_pe[d], exp_pe[d]);
      check({name, " overrun count"}, seen_ov[d], exp_ov[d]);
    end
  endtask

  initial begin
    int t0;
    line0 = 1'b1;
    line1 = 1'b1;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Single clean frame, latency and hold while not ready
    send_frame(0, 8'hA5, -1, 2'b11, 1'b1, t0);
    repeat (3) @(negedge clk);
    check_rng("A5 valid latency", rise0 - t0, 76, 81);
    check("A5 head", data0, 8'hA5);
    check("A5 count", cnt0, 1);
    repeat (10) @(negedge clk);
    check("A5 held", data0, 8'hA5);
    want0 = 1'b1;
    drain("A5");
    chk_errs("A5");

    // Start-bit glitch
    @(posedge clk);
    #1;
    busy0_seen = 1'b0;
    line0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    line0 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("glitch busy seen", busy0_seen, 1);
    check("glitch busy cleared", busy0, 0);
    check("glitch count", cnt0, 0);
    chk_errs("glitch");

    // Bad stop bit then a held break
    send_frame(0, 8'h3C, -1, 2'b00, 1'b0, t0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("break still busy", busy0, 1);
    check("break count", cnt0, 0);
    chk_errs("break");
    @(posedge clk);
    #1;
    line0 = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("break released", busy0, 0);

    // Even parity: wrong then right parity bit
    send_frame(1, 8'h07, 0, 2'b11, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("par bad count", cnt1, 0);
    chk_errs("par bad");
    want1 = 1'b1;
    send_frame(1, 8'h07, 1, 2'b11, 1'b1, t0);
    drain("par good");
    chk_errs("par good");

    // Fill past capacity with consumer stalled
    want0 = 1'b0;
    for (int i = 0; i < 16; i++)
      send_frame(0, 8'(i), -1, 2'b11, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("fill count", cnt0, 16);
    check("fill no overrun", seen_ov[0], exp_ov[0]);
    send_frame(0, 8'h10, -1, 2'b11, 1'b1, t0);
    repeat (4) @(negedge clk);
    check("full count", cnt0, 16);
    check("full head", data0, 8'h00);
    chk_errs("overrun");
    want0 = 1'b1;
    drain("overrun");

    // Reset during data bit 4 of 0xFF
    fork
      send_frame(0, 8'hFF, -1, 2'b11, 1'b1, t0);
      begin
        @(posedge clk);
        repeat (44) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("midframe reset");
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    send_frame(0, 8'h12, -1, 2'b11, 1'b1, t0);
    drain("post reset");
    chk_errs("post reset");

    // Random traffic with injected errors and random back-pressure
    rnd_rdy = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        int r;
        r = $urandom_range(0, 9);
        send_frame(0, 8'($urandom), -1, (r == 0) ? 2'b10 : 2'b11,
                   1'b1, t0);
        repeat ($urandom_range(2, 6)) @(posedge clk);
      end
      for (int i = 0; i < 25; i++) begin
        int r;
        logic [7:0] w;
        w = 8'($urandom);
        r = $urandom_range(0, 9);
        if (r == 0)
          send_frame(1, w, -1, 2'($urandom_range(0, 2)), 1'b1, t0);
        else if (r == 1)
          send_frame(1, w, int'(~^w), 2'b11, 1'b1, t0);
        else
          send_frame(1, w, -1, 2'b11, 1'b1, t0);
        repeat ($urandom_range(2, 6)) @(posedge clk);
      end
    join
    rnd_rdy = 1'b0;
    want0   = 1'b1;
    want1   = 1'b1;
    drain("random");
    chk_errs("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250: sysclk cycles per UART bit, minimum 4.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked per frame, 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: output buffer depth, a power of 2, at least 2.
REQ-006 Port list, clock and reset first:
- sysclk  in  1  -- single clock; all logic on its rising edge.
- reset  in  1  -- synchronous, active-high.
- uart_txd_in  in  1  -- asynchronous serial line, idle high, LSB first.
- m_data  out  DATA_BITS  -- received word at FIFO head.
- m_valid  out  1  -- FIFO not empty.
- m_ready  in  1  -- consumer accepts m_data.
- frame_err  out  1  -- one-cycle pulse.
- parity_err  out  1  -- one-cycle pulse.
- overrun  out  1  -- one-cycle pulse.
- fifo_count  out  clog2(FIFO_DEPTH)+1  -- words held.
- rx_busy  out  1  -- FSM is not in IDLE.

Function
REQ-007 SHALL pass uart_txd_in through a 2-flop synchroniser; all further logic uses only the synchronised line.
REQ-008 FSM states SHALL be IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-009 IDLE->START SHALL occur on a synchronised high-to-low transition.
REQ-010 START: after CLKS_PER_BIT/2 cycles, sample the line: low -> DATA, high -> IDLE (glitch, no error, nothing pushed).
REQ-011 DATA SHALL sample every CLKS_PER_BIT cycles from the start-bit midpoint, shifting DATA_BITS bits LSB first.
REQ-012 Next state after DATA SHALL be PAR when PARITY!=0, else STOP.
REQ-013 PAR SHALL sample one bit; a mismatch with the even/odd parity of the data bits sets an internal error flag for the frame.
REQ-014 STOP SHALL sample STOP_BITS bits at one-bit intervals.
REQ-015 Any stop sample at 0 SHALL pulse frame_err, discard the word, and go to WAIT_HIGH.
REQ-016 WAIT_HIGH SHALL stay until the synchronised line is 1, then go to IDLE (break handling).
REQ-017 On the last stop sample with parity flagged, parity_err SHALL pulse, the word SHALL be discarded, and the FSM SHALL go to IDLE.
REQ-018 On the last stop sample with no error, the word SHALL be pushed, and the FSM SHALL go to IDLE in that cycle.
REQ-019 Frame errors SHALL take priority: a frame with both errors pulses frame_err only.
REQ-020 FIFO SHALL be first-word-fall-through: m_valid and m_data update the cycle after a push into an empty FIFO.
REQ-021 A pop SHALL occur when m_valid && m_ready; m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-022 A push into a full FIFO SHALL be accepted if a pop occurs in the same cycle; otherwise the word is dropped, overrun pulses, and stored contents are unchanged.
REQ-023 Simultaneous push and pop on a non-empty FIFO SHALL leave fifo_count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Bit timing counter SHALL be clog2(CLKS_PER_BIT)+1 bits and SHALL reload on every sample.

Reset
REQ-026 reset SHALL force state IDLE, synchroniser flops to 1, FIFO empty, fifo_count=0, m_valid=0, m_data=0, all error pulses 0, rx_busy=0.
REQ-027 reset mid-frame SHALL abandon the partial word; the next falling edge after reset deasserts begins a new frame.

Structure
REQ-028 Shared package SHALL hold parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD) and the FSM state enum.
REQ-029 The FIFO SHALL be one sub-module, sync_fifo, parametrised by width and depth and exposing count; the FSM and shifter stay in uart_rx_fifo.

Verification (CLKS_PER_BIT=8 unless noted)
REQ-030 Send 0xA5, no parity, 1 stop -> m_data=0xA5 with m_valid=1 one cycle after the stop midpoint; no error pulses.
REQ-031 Drive a 3-cycle low glitch on an idle line -> no push, no errors, rx_busy back to 0 by cycle 8.
REQ-032 Send 0x3C with stop bit 0, then hold the line low 40 cycles -> one frame_err pulse, fifo_count=0, FSM leaves WAIT_HIGH only after the line returns high.
REQ-033 PARITY=1, send 0x07 with parity bit 0 -> one parity_err pulse, no push; repeat with parity bit 1 -> 0x07 delivered.
REQ-034 With m_ready=0, send 17 words 0x00..0x10 -> fifo_count=16 and one overrun on word 0x10; then m_ready=1 -> 0x00..0x0F read out in order.
REQ-035 Assert reset during data bit 4 of 0xFF, release, send 0x12 -> only 0x12 received; outputs match their REQ-026 values during reset.
